// File: rtl/tlx_fwd_arbiter.sv
// Two-requester, packet-atomic, credit-gated round-robin arbiter in front of the TLX FWD payload link.
// Define TLX_FWD_ARB_STATS_EN to add the STALL0/STALL1 back-pressure counters.
module tlx_fwd_arbiter #(
    parameter int CREDIT_W    = 4,
    parameter int CREDIT_INIT = 8
) (
    input  logic                CLK,
    input  logic                RESETn,
    input  logic                REQ0_TVALID,
    output logic                REQ0_TREADY,
    input  logic [39:0]         REQ0_TDATA,
    input  logic                REQ0_TLAST,
    input  logic                REQ1_TVALID,
    output logic                REQ1_TREADY,
    input  logic [39:0]         REQ1_TDATA,
    input  logic                REQ1_TLAST,
    output logic                TLX_FWD_PAYLOAD_TVALID,
    input  logic                TLX_FWD_PAYLOAD_TREADY,
    output logic [39:0]         TLX_FWD_PAYLOAD_TDATA,
    input  logic                TLX_FWD_FLOW_TVALID,
    output logic                TLX_FWD_FLOW_TREADY,
    input  logic [1:0]          TLX_FWD_FLOW_TDATA,
    output logic [CREDIT_W-1:0] CREDIT0,
    output logic [CREDIT_W-1:0] CREDIT1,
    output logic                CREDIT_ERR
`ifdef TLX_FWD_ARB_STATS_EN
    ,
    output logic [15:0]         STALL0,
    output logic [15:0]         STALL1
`endif
);

    localparam logic [CREDIT_W-1:0] CREDIT_MAX = '1;
    localparam logic [CREDIT_W-1:0] CREDIT_RST = CREDIT_W'(CREDIT_INIT);

    typedef enum logic [1:0] {IDLE, LOCK0, LOCK1} state_t;

    state_t              state_reg, state_next;
    logic                prio_reg, prio_next;
    logic                out_valid_reg;
    logic [39:0]         out_data_reg;
    logic                flow_ready_reg;
    logic                err_reg;
    logic                out_ready;
    logic                flow_fire;
    logic                sel;
    logic                accept;
    logic [1:0]          req_valid;
    logic [1:0]          req_last;
    logic [1:0]          req_ready;
    logic [1:0]          has_credit;
    logic [1:0]          eligible;
    logic [1:0]          overflow;
    logic [CREDIT_W-1:0] credit [2];

    assign req_valid = {REQ1_TVALID, REQ0_TVALID};
    assign req_last  = {REQ1_TLAST, REQ0_TLAST};
    assign out_ready = !out_valid_reg || TLX_FWD_PAYLOAD_TREADY;
    assign flow_fire = TLX_FWD_FLOW_TVALID && flow_ready_reg;
    assign eligible  = req_valid & has_credit;

    always_comb begin
        state_next = state_reg;
        prio_next  = prio_reg;
        sel        = prio_reg;
        req_ready  = 2'b00;
        accept     = 1'b0;
        case (state_reg)
            IDLE: begin
                if (eligible == 2'b11) sel = prio_reg;
                else                   sel = eligible[1];
                req_ready = sel ? {out_ready && eligible[1], 1'b0}
                                : {1'b0, out_ready && eligible[0]};
            end
            // Locked states ignore TVALID so a packet can never be split.
            LOCK0: begin
                sel       = 1'b0;
                req_ready = {1'b0, out_ready && has_credit[0]};
            end
            LOCK1: begin
                sel       = 1'b1;
                req_ready = {out_ready && has_credit[1], 1'b0};
            end
            default: state_next = IDLE;
        endcase
        accept = req_valid[sel] && req_ready[sel];
        if (accept) begin
            if (req_last[sel]) begin
                state_next = IDLE;
                prio_next  = !sel;
            end else begin
                state_next = sel ? LOCK1 : LOCK0;
            end
        end
    end

    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            state_reg      <= IDLE;
            prio_reg       <= 1'b0;
            out_valid_reg  <= 1'b0;
            out_data_reg   <= '0;
            flow_ready_reg <= 1'b0;
            err_reg        <= 1'b0;
        end else begin
            state_reg      <= state_next;
            prio_reg       <= prio_next;
            flow_ready_reg <= 1'b1;
            if (out_ready) begin
                out_valid_reg <= accept;
                if (accept) out_data_reg <= sel ? REQ1_TDATA : REQ0_TDATA;
            end
            if (|overflow) err_reg <= 1'b1;
        end
    end

`ifdef TLX_FWD_ARB_STATS_EN
    logic [15:0] stall [2];
`endif

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_class
            logic [CREDIT_W-1:0] count_reg;
            logic                inc;
            logic                dec;

            assign inc            = flow_fire && TLX_FWD_FLOW_TDATA[gi];
            assign dec            = accept && (sel == 1'(gi));
            assign overflow[gi]   = inc && !dec && (count_reg == CREDIT_MAX);
            assign has_credit[gi] = (count_reg != '0);
            assign credit[gi]     = count_reg;

            // A return and a spend in the same cycle cancel out.
            always_ff @(posedge CLK or negedge RESETn) begin
                if (!RESETn)
                    count_reg <= CREDIT_RST;
                else if (inc && !dec && count_reg != CREDIT_MAX)
                    count_reg <= count_reg + 1'b1;
                else if (dec && !inc)
                    count_reg <= count_reg - 1'b1;
            end

`ifdef TLX_FWD_ARB_STATS_EN
            logic [15:0] stall_reg;
            always_ff @(posedge CLK or negedge RESETn) begin
                if (!RESETn)
                    stall_reg <= '0;
                else if (req_valid[gi] && !req_ready[gi] && stall_reg != 16'hFFFF)
                    stall_reg <= stall_reg + 16'd1;
            end
            assign stall[gi] = stall_reg;
`endif
        end
    endgenerate

    assign REQ0_TREADY            = req_ready[0];
    assign REQ1_TREADY            = req_ready[1];
    assign TLX_FWD_PAYLOAD_TVALID = out_valid_reg;
    assign TLX_FWD_PAYLOAD_TDATA  = out_data_reg;
    assign TLX_FWD_FLOW_TREADY    = flow_ready_reg;
    assign CREDIT0                = credit[0];
    assign CREDIT1                = credit[1];
    assign CREDIT_ERR             = err_reg;
`ifdef TLX_FWD_ARB_STATS_EN
    assign STALL0                 = stall[0];
    assign STALL1                 = stall[1];
`endif

endmodule

// File: tb/tb_tlx_fwd_arbiter.sv
// Directed scoreboard bench for tlx_fwd_arbiter: arbitration order, atomicity, credits, backpressure, reset.
module tb_tlx_fwd_arbiter;

    logic        CLK = 1'b0;
    logic        RESETn;
    logic        REQ0_TVALID, REQ0_TREADY, REQ0_TLAST;
    logic        REQ1_TVALID, REQ1_TREADY, REQ1_TLAST;
    logic [39:0] REQ0_TDATA, REQ1_TDATA;
    logic        TLX_FWD_PAYLOAD_TVALID, TLX_FWD_PAYLOAD_TREADY;
    logic [39:0] TLX_FWD_PAYLOAD_TDATA;
    logic        TLX_FWD_FLOW_TVALID, TLX_FWD_FLOW_TREADY;
    logic [1:0]  TLX_FWD_FLOW_TDATA;
    logic [3:0]  CREDIT0, CREDIT1;
    logic        CREDIT_ERR;

    int checks = 0;
    int errors = 0;

    logic [40:0] src0_q[$];
    logic [40:0] src1_q[$];
    logic [39:0] exp_q[$];

    always #5 CLK = ~CLK;

    tlx_fwd_arbiter #(.CREDIT_W(4), .CREDIT_INIT(8)) dut (
        .CLK                    (CLK),
        .RESETn                 (RESETn),
        .REQ0_TVALID            (REQ0_TVALID),
        .REQ0_TREADY            (REQ0_TREADY),
        .REQ0_TDATA             (REQ0_TDATA),
        .REQ0_TLAST             (REQ0_TLAST),
        .REQ1_TVALID            (REQ1_TVALID),
        .REQ1_TREADY            (REQ1_TREADY),
        .REQ1_TDATA             (REQ1_TDATA),
        .REQ1_TLAST             (REQ1_TLAST),
        .TLX_FWD_PAYLOAD_TVALID (TLX_FWD_PAYLOAD_TVALID),
        .TLX_FWD_PAYLOAD_TREADY (TLX_FWD_PAYLOAD_TREADY),
        .TLX_FWD_PAYLOAD_TDATA  (TLX_FWD_PAYLOAD_TDATA),
        .TLX_FWD_FLOW_TVALID    (TLX_FWD_FLOW_TVALID),
        .TLX_FWD_FLOW_TREADY    (TLX_FWD_FLOW_TREADY),
        .TLX_FWD_FLOW_TDATA     (TLX_FWD_FLOW_TDATA),
        .CREDIT0                (CREDIT0),
        .CREDIT1                (CREDIT1),
        .CREDIT_ERR             (CREDIT_ERR)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic present();
        if (src0_q.size() > 0) begin
            REQ0_TVALID = 1'b1;
            {REQ0_TLAST, REQ0_TDATA} = src0_q[0];
        end else begin
            REQ0_TVALID = 1'b0;
            REQ0_TLAST  = 1'b0;
            REQ0_TDATA  = '0;
        end
        if (src1_q.size() > 0) begin
            REQ1_TVALID = 1'b1;
            {REQ1_TLAST, REQ1_TDATA} = src1_q[0];
        end else begin
            REQ1_TVALID = 1'b0;
            REQ1_TLAST  = 1'b0;
            REQ1_TDATA  = '0;
        end
    endtask

    // One clock: sample mid-cycle, score any payload handshake, then advance the sources.
    task automatic cycle();
        logic        hs0, hs1;
        logic [39:0] exp_d;
        @(negedge CLK);
        hs0 = REQ0_TVALID && REQ0_TREADY;
        hs1 = REQ1_TVALID && REQ1_TREADY;
        if (TLX_FWD_PAYLOAD_TVALID && TLX_FWD_PAYLOAD_TREADY) begin
            chk("unexpected_beat", 64'(exp_q.size() > 0), 64'd1);
            if (exp_q.size() > 0) begin
                exp_d = exp_q.pop_front();
                $display("beat out data=%h expected=%h", TLX_FWD_PAYLOAD_TDATA, exp_d);
                chk("payload_order", 64'(TLX_FWD_PAYLOAD_TDATA), 64'(exp_d));
            end
        end
        @(posedge CLK);
        #1;
        if (hs0 && src0_q.size() > 0) void'(src0_q.pop_front());
        if (hs1 && src1_q.size() > 0) void'(src1_q.pop_front());
        present();
    endtask

    task automatic drain(input string tag);
        int n = 0;
        while ((src0_q.size() + src1_q.size() + exp_q.size()) != 0 && n < 200) begin
            cycle();
            n++;
        end
        chk(tag, 64'(src0_q.size() + src1_q.size() + exp_q.size()), 64'd0);
    endtask

    task automatic flow(input logic [1:0] bits, input int n);
        TLX_FWD_FLOW_TVALID = 1'b1;
        TLX_FWD_FLOW_TDATA  = bits;
        repeat (n) cycle();
        TLX_FWD_FLOW_TVALID = 1'b0;
        TLX_FWD_FLOW_TDATA  = 2'b00;
    endtask

    initial begin
        RESETn = 1'b0;
        REQ0_TVALID = 1'b0; REQ0_TLAST = 1'b0; REQ0_TDATA = '0;
        REQ1_TVALID = 1'b0; REQ1_TLAST = 1'b0; REQ1_TDATA = '0;
        TLX_FWD_PAYLOAD_TREADY = 1'b1;
        TLX_FWD_FLOW_TVALID = 1'b0; TLX_FWD_FLOW_TDATA = 2'b00;

        // Reset defaults
        repeat (3) @(posedge CLK);
        #1;
        chk("rst_pvalid", 64'(TLX_FWD_PAYLOAD_TVALID), 64'd0);
        chk("rst_pdata", 64'(TLX_FWD_PAYLOAD_TDATA), 64'd0);
        chk("rst_flow_ready", 64'(TLX_FWD_FLOW_TREADY), 64'd0);
        chk("rst_ready0", 64'(REQ0_TREADY), 64'd0);
        chk("rst_ready1", 64'(REQ1_TREADY), 64'd0);
        chk("rst_credit0", 64'(CREDIT0), 64'd8);
        chk("rst_credit1", 64'(CREDIT1), 64'd8);
        chk("rst_err", 64'(CREDIT_ERR), 64'd0);
        RESETn = 1'b1;
        #1;
        chk("flow_ready_before_edge", 64'(TLX_FWD_FLOW_TREADY), 64'd0);
        @(posedge CLK);
        #1;
        chk("flow_ready_after_edge", 64'(TLX_FWD_FLOW_TREADY), 64'd1);
        chk("idle_pvalid", 64'(TLX_FWD_PAYLOAD_TVALID), 64'd0);

        // Round-robin on single-beat packets
        src0_q.push_back({1'b1, 40'hA0_0000_0000}); src0_q.push_back({1'b1, 40'hA0_0000_0001});
        src1_q.push_back({1'b1, 40'hB1_0000_0000}); src1_q.push_back({1'b1, 40'hB1_0000_0001});
        exp_q.push_back(40'hA0_0000_0000); exp_q.push_back(40'hB1_0000_0000);
        exp_q.push_back(40'hA0_0000_0001); exp_q.push_back(40'hB1_0000_0001);
        present();
        drain("rr_drain");
        chk("rr_credit0", 64'(CREDIT0), 64'd6);
        chk("rr_credit1", 64'(CREDIT1), 64'd6);

        // Packet atomicity: 3-beat packet from 0 while 1 waits
        src0_q.push_back({1'b0, 40'hC0_0000_0000}); src0_q.push_back({1'b0, 40'hC0_0000_0001});
        src0_q.push_back({1'b1, 40'hC0_0000_0002});
        src1_q.push_back({1'b1, 40'hD1_0000_0000});
        exp_q.push_back(40'hC0_0000_0000); exp_q.push_back(40'hC0_0000_0001);
        exp_q.push_back(40'hC0_0000_0002); exp_q.push_back(40'hD1_0000_0000);
        present();
        drain("atomic_drain");
        chk("atomic_credit0", 64'(CREDIT0), 64'd3);
        chk("atomic_credit1", 64'(CREDIT1), 64'd5);

        // Bring class 0 down to 2 credits, priority back to requester 0
        src0_q.push_back({1'b1, 40'hE0_0000_0000});
        src1_q.push_back({1'b1, 40'hE1_0000_0000});
        exp_q.push_back(40'hE0_0000_0000); exp_q.push_back(40'hE1_0000_0000);
        present();
        drain("pre_exhaust_drain");
        chk("pre_exhaust_credit0", 64'(CREDIT0), 64'd2);

        // Credit exhaustion mid-packet
        src0_q.push_back({1'b0, 40'hF0_0000_0000}); src0_q.push_back({1'b0, 40'hF0_0000_0001});
        src0_q.push_back({1'b0, 40'hF0_0000_0002}); src0_q.push_back({1'b1, 40'hF0_0000_0003});
        src1_q.push_back({1'b1, 40'h61_0000_0000});
        exp_q.push_back(40'hF0_0000_0000); exp_q.push_back(40'hF0_0000_0001);
        present();
        cycle();
        cycle();
        for (int i = 0; i < 4; i++) begin
            cycle();
            chk("exhaust_ready0", 64'(REQ0_TREADY), 64'd0);
            chk("exhaust_ready1", 64'(REQ1_TREADY), 64'd0);
        end
        chk("exhaust_credit0", 64'(CREDIT0), 64'd0);
        chk("exhaust_sb_empty", 64'(exp_q.size()), 64'd0);
        exp_q.push_back(40'hF0_0000_0002);
        flow(2'b01, 1);
        chk("release_credit0", 64'(CREDIT0), 64'd1);
        chk("release_ready0", 64'(REQ0_TREADY), 64'd1);
        cycle();
        cycle();
        chk("restall_ready0", 64'(REQ0_TREADY), 64'd0);
        chk("restall_ready1", 64'(REQ1_TREADY), 64'd0);
        exp_q.push_back(40'hF0_0000_0003); exp_q.push_back(40'h61_0000_0000);
        flow(2'b01, 1);
        drain("exhaust_drain");
        chk("exhaust_end_credit0", 64'(CREDIT0), 64'd0);
        chk("exhaust_end_credit1", 64'(CREDIT1), 64'd3);

        // Refill both classes
        flow(2'b11, 4);
        chk("refill_credit0", 64'(CREDIT0), 64'd4);
        chk("refill_credit1", 64'(CREDIT1), 64'd7);

        // Backpressure
        TLX_FWD_PAYLOAD_TREADY = 1'b0;
        src0_q.push_back({1'b1, 40'h70_0000_0000}); src0_q.push_back({1'b1, 40'h70_0000_0001});
        exp_q.push_back(40'h70_0000_0000); exp_q.push_back(40'h70_0000_0001);
        present();
        cycle();
        for (int i = 0; i < 5; i++) begin
            cycle();
            chk("bp_pvalid", 64'(TLX_FWD_PAYLOAD_TVALID), 64'd1);
            chk("bp_pdata", 64'(TLX_FWD_PAYLOAD_TDATA), 64'h70_0000_0000);
            chk("bp_ready0", 64'(REQ0_TREADY), 64'd0);
            chk("bp_credit0", 64'(CREDIT0), 64'd3);
        end
        TLX_FWD_PAYLOAD_TREADY = 1'b1;
        drain("bp_drain");
        chk("bp_end_credit0", 64'(CREDIT0), 64'd2);

        // Overflow: fill class 1 to 15, then return 8 more
        flow(2'b10, 8);
        chk("fill_credit1", 64'(CREDIT1), 64'd15);
        chk("fill_err", 64'(CREDIT_ERR), 64'd0);
        flow(2'b10, 8);
        chk("ovf_credit1", 64'(CREDIT1), 64'd15);
        chk("ovf_err", 64'(CREDIT_ERR), 64'd1);

        // Simultaneous return and spend on class 0
        src0_q.push_back({1'b1, 40'h80_0000_0000});
        exp_q.push_back(40'h80_0000_0000);
        present();
        flow(2'b01, 1);
        chk("simul_credit0", 64'(CREDIT0), 64'd2);
        drain("simul_drain");
        chk("err_sticky", 64'(CREDIT_ERR), 64'd1);

        // Reset in the middle of a packet
        src0_q.push_back({1'b0, 40'h90_0000_0000}); src0_q.push_back({1'b0, 40'h90_0000_0001});
        present();
        cycle();
        RESETn = 1'b0;
        #1;
        chk("midrst_pvalid", 64'(TLX_FWD_PAYLOAD_TVALID), 64'd0);
        chk("midrst_pdata", 64'(TLX_FWD_PAYLOAD_TDATA), 64'd0);
        chk("midrst_credit0", 64'(CREDIT0), 64'd8);
        chk("midrst_credit1", 64'(CREDIT1), 64'd8);
        chk("midrst_err", 64'(CREDIT_ERR), 64'd0);
        chk("midrst_flow_ready", 64'(TLX_FWD_FLOW_TREADY), 64'd0);
        src0_q.delete();
        src1_q.delete();
        present();
        @(posedge CLK);
        #1;
        RESETn = 1'b1;
        @(posedge CLK);
        #1;
        src1_q.push_back({1'b1, 40'h91_0000_0000});
        exp_q.push_back(40'h91_0000_0000);
        present();
        drain("post_rst_drain");
        chk("post_rst_credit1", 64'(CREDIT1), 64'd7);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
